// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor
//
// Passive tap on a VGA sync/RGB stream. On ARM it waits for a VSYNC event, then
// samples V_LINES lines of H_PIX pixels each, one sample every CLK_PER_PIX clocks,
// with the first sample of each line taken H_OFFSET clocks after the HSYNC event.
// Every sample is classified as foreground, background or other, and folded into
// a rotate-and-XOR signature. Results are held behind a sticky DONE until the next
// accepted ARM.
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous, active-high reset
//   hsync_i        horizontal sync, synchronous to clk_i
//   vsync_i        vertical sync, synchronous to clk_i
//   rgb_i          pixel data
//   arm_i          single-cycle start request (ignored while busy_o)
//   busy_o         capture in progress
//   done_o         sticky result-valid, cleared by an accepted ARM
//   fg_cnt_o       samples equal to FG_COLOR (saturating)
//   bg_cnt_o       samples equal to BG_COLOR (saturating)
//   other_cnt_o    all remaining samples (saturating)
//   sig_o          frame signature
//   line_err_o     sticky: HSYNC event arrived before a line was complete
//   frame_err_o    sticky: VSYNC event arrived before the frame was complete

module vga_frame_monitor #(
    parameter int unsigned       RGB_W       = 8,
    parameter int unsigned       H_PIX       = 705,
    parameter int unsigned       V_LINES     = 520,
    parameter int unsigned       CLK_PER_PIX = 4,
    parameter int unsigned       H_OFFSET    = 0,
    parameter int unsigned       SYNC_RISE   = 1,
    parameter logic [RGB_W-1:0]  FG_COLOR    = 8'h1C,
    parameter logic [RGB_W-1:0]  BG_COLOR    = 8'h00,
    parameter int unsigned       CNT_W       = 20,
    parameter int unsigned       SIG_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic [RGB_W-1:0] rgb_i,
    input  logic             arm_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] fg_cnt_o,
    output logic [CNT_W-1:0] bg_cnt_o,
    output logic [CNT_W-1:0] other_cnt_o,
    output logic [SIG_W-1:0] sig_o,
    output logic             line_err_o,
    output logic             frame_err_o
);

    // Phase counter must hold both the line-start offset and the pixel period.
    localparam int unsigned PH_MAX = (H_OFFSET > CLK_PER_PIX) ? H_OFFSET : CLK_PER_PIX;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
    localparam int unsigned PIX_W  = $clog2(H_PIX + 1);
    localparam int unsigned LINE_W = $clog2(V_LINES + 1);

    localparam logic [PH_W-1:0]   PH_RELOAD = PH_W'(CLK_PER_PIX - 1);
    // The event cycle itself counts as the first offset clock, hence the -1.
    localparam logic [PH_W-1:0]   PH_OFFS   = PH_W'((H_OFFSET == 0) ? 0 : H_OFFSET - 1);
    localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(H_PIX - 1);
    localparam logic [PIX_W-1:0]  PIX_FULL  = PIX_W'(H_PIX);
    localparam logic [LINE_W-1:0] LINE_FULL = LINE_W'(V_LINES);

    typedef enum logic [2:0] {
        StIdle,
        StWaitV,
        StWaitH,
        StSample,
        StFin
    } state_e;

    state_e             state_q, state_d;
    logic               hs_q, vs_q;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [CNT_W-1:0]   fg_q, fg_d;
    logic [CNT_W-1:0]   bg_q, bg_d;
    logic [CNT_W-1:0]   oth_q, oth_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic               done_q, done_d;
    logic               lerr_q, lerr_d;
    logic               ferr_q, ferr_d;

    logic               hs_ev, vs_ev;
    logic               start_line, take;
    logic [PIX_W-1:0]   pix_base, pix_inc;
    logic [LINE_W-1:0]  line_base, line_inc;

    // Sync event: the active level appears while the history register still
    // holds the inactive level.
    assign hs_ev = (SYNC_RISE != 0) ? (hsync_i & ~hs_q) : (~hsync_i & hs_q);
    assign vs_ev = (SYNC_RISE != 0) ? (vsync_i & ~vs_q) : (~vsync_i & vs_q);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        pix_d      = pix_q;
        line_d     = line_q;
        fg_d       = fg_q;
        bg_d       = bg_q;
        oth_d      = oth_q;
        sig_d      = sig_q;
        done_d     = done_q;
        lerr_d     = lerr_q;
        ferr_d     = ferr_q;
        start_line = 1'b0;
        take       = 1'b0;
        pix_base   = pix_q;
        line_base  = line_q;
        pix_inc    = '0;
        line_inc   = '0;

        unique case (state_q)
            StIdle: begin
                if (arm_i) begin
                    fg_d    = '0;
                    bg_d    = '0;
                    oth_d   = '0;
                    sig_d   = '0;
                    done_d  = 1'b0;
                    lerr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    state_d = StWaitV;
                end
            end
            StWaitV: begin
                if (vs_ev) begin
                    line_d  = '0;
                    state_d = StWaitH;
                end
            end
            StWaitH: begin
                if (vs_ev) begin
                    ferr_d  = 1'b1;
                    state_d = StFin;
                end else if (hs_ev) begin
                    start_line = 1'b1;
                end
            end
            StSample: begin
                if (vs_ev) begin
                    ferr_d  = 1'b1;
                    state_d = StFin;
                end else if (hs_ev && !(phase_q == '0 && pix_q == LAST_PIX)) begin
                    // Short line: close it out and restart from this event.
                    lerr_d    = 1'b1;
                    line_base = line_q + 1'b1;
                    line_d    = line_base;
                    if (line_base == LINE_FULL) begin
                        state_d = StFin;
                    end else begin
                        start_line = 1'b1;
                    end
                end else if (phase_q == '0) begin
                    // Final-sample cycle lands here even with a concurrent HSYNC.
                    take = 1'b1;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            StFin: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start_line) begin
            pix_base = '0;
            pix_d    = '0;
            state_d  = StSample;
            if (H_OFFSET == 0) begin
                take = 1'b1;
            end else begin
                phase_d = PH_OFFS;
            end
        end

        if (take) begin
            if (rgb_i == FG_COLOR) begin
                if (fg_q != '1) fg_d = fg_q + 1'b1;
            end else if (rgb_i == BG_COLOR) begin
                if (bg_q != '1) bg_d = bg_q + 1'b1;
            end else begin
                if (oth_q != '1) oth_d = oth_q + 1'b1;
            end
            sig_d   = {sig_q[SIG_W-2:0], sig_q[SIG_W-1]} ^ SIG_W'(rgb_i);
            phase_d = PH_RELOAD;
            pix_inc = pix_base + 1'b1;
            pix_d   = pix_inc;
            if (pix_inc == PIX_FULL) begin
                line_inc = line_base + 1'b1;
                line_d   = line_inc;
                state_d  = (line_inc == LINE_FULL) ? StFin : StWaitH;
            end else begin
                state_d = StSample;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            phase_q <= '0;
            pix_q   <= '0;
            line_q  <= '0;
            fg_q    <= '0;
            bg_q    <= '0;
            oth_q   <= '0;
            sig_q   <= '0;
            done_q  <= 1'b0;
            lerr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hs_q    <= hsync_i;
            vs_q    <= vsync_i;
            phase_q <= phase_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
            oth_q   <= oth_d;
            sig_q   <= sig_d;
            done_q  <= done_d;
            lerr_q  <= lerr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign busy_o      = (state_q == StWaitV) || (state_q == StWaitH) || (state_q == StSample);
    assign done_o      = done_q;
    assign fg_cnt_o    = fg_q;
    assign bg_cnt_o    = bg_q;
    assign other_cnt_o = oth_q;
    assign sig_o       = sig_q;
    assign line_err_o  = lerr_q;
    assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor with H_PIX=4, V_LINES=2, CLK_PER_PIX=2.
// Three instances share one stimulus stream: A (rising syncs, H_OFFSET=0),
// B (falling syncs on inverted HSYNC/VSYNC), C (H_OFFSET=3, RGB delayed 3 clocks).

module tb_vga_frame_monitor;

    localparam int unsigned CNT_W = 20;
    localparam int unsigned SIG_W = 16;
    localparam logic [7:0]  JUNK  = 8'hAA;

    typedef struct {
        string       name;
        int          kind;   // 0 clean, 1 early HSYNC, 2 early VSYNC
        logic [63:0] pix;    // pixel k at [63-8k -: 8]
        int          nsamp;
        int          fg;
        int          bg;
        int          oth;
        logic        lerr;
        logic        ferr;
        logic [15:0] sig;
    } vec_t;

    logic clk = 1'b0;
    logic rst, hs, vs, arm, hs_n, vs_n;
    logic [7:0] rgb, rgb_d1, rgb_d2, rgb_d3;

    logic [2:0]       busy, done, lerr, ferr;
    logic [CNT_W-1:0] fg  [3];
    logic [CNT_W-1:0] bg  [3];
    logic [CNT_W-1:0] oth [3];
    logic [SIG_W-1:0] sig [3];

    int n_vec = 0;
    int n_err = 0;

    vec_t tv [5];
    vec_t exp_q [$];

    always #5 clk = ~clk;

    assign hs_n = ~hs;
    assign vs_n = ~vs;

    always @(posedge clk) begin
        rgb_d1 <= rgb;
        rgb_d2 <= rgb_d1;
        rgb_d3 <= rgb_d2;
    end

    vga_frame_monitor #(.RGB_W(8), .H_PIX(4), .V_LINES(2), .CLK_PER_PIX(2), .H_OFFSET(0),
        .SYNC_RISE(1), .FG_COLOR(8'h1C), .BG_COLOR(8'h00), .CNT_W(CNT_W), .SIG_W(SIG_W)) dut_a (
        .clk_i(clk), .rst_i(rst), .hsync_i(hs), .vsync_i(vs), .rgb_i(rgb), .arm_i(arm),
        .busy_o(busy[0]), .done_o(done[0]), .fg_cnt_o(fg[0]), .bg_cnt_o(bg[0]),
        .other_cnt_o(oth[0]), .sig_o(sig[0]), .line_err_o(lerr[0]), .frame_err_o(ferr[0])
    );

    vga_frame_monitor #(.RGB_W(8), .H_PIX(4), .V_LINES(2), .CLK_PER_PIX(2), .H_OFFSET(0),
        .SYNC_RISE(0), .FG_COLOR(8'h1C), .BG_COLOR(8'h00), .CNT_W(CNT_W), .SIG_W(SIG_W)) dut_b (
        .clk_i(clk), .rst_i(rst), .hsync_i(hs_n), .vsync_i(vs_n), .rgb_i(rgb), .arm_i(arm),
        .busy_o(busy[1]), .done_o(done[1]), .fg_cnt_o(fg[1]), .bg_cnt_o(bg[1]),
        .other_cnt_o(oth[1]), .sig_o(sig[1]), .line_err_o(lerr[1]), .frame_err_o(ferr[1])
    );

    vga_frame_monitor #(.RGB_W(8), .H_PIX(4), .V_LINES(2), .CLK_PER_PIX(2), .H_OFFSET(3),
        .SYNC_RISE(1), .FG_COLOR(8'h1C), .BG_COLOR(8'h00), .CNT_W(CNT_W), .SIG_W(SIG_W)) dut_c (
        .clk_i(clk), .rst_i(rst), .hsync_i(hs), .vsync_i(vs), .rgb_i(rgb_d3), .arm_i(arm),
        .busy_o(busy[2]), .done_o(done[2]), .fg_cnt_o(fg[2]), .bg_cnt_o(bg[2]),
        .other_cnt_o(oth[2]), .sig_o(sig[2]), .line_err_o(lerr[2]), .frame_err_o(ferr[2])
    );

    function automatic logic [7:0] px(input logic [63:0] p, input int k);
        return p[63-8*k -: 8];
    endfunction

    function automatic logic [15:0] model_sig(input logic [63:0] p, input int n);
        logic [15:0] s;
        s = 16'h0000;
        for (int k = 0; k < n; k++) s = {s[14:0], s[15]} ^ {8'h00, px(p, k)};
        return s;
    endfunction

    function automatic vec_t mk(input string n, input int k, input logic [63:0] p,
                                input int ns, input int f, input int b, input int o,
                                input logic le, input logic fe);
        vec_t v;
        v.name = n; v.kind = k; v.pix = p; v.nsamp = ns;
        v.fg = f; v.bg = b; v.oth = o; v.lerr = le; v.ferr = fe;
        v.sig = model_sig(p, ns);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic h, input logic v, input logic [7:0] p);
        hs = h; vs = v; rgb = p;
        @(negedge clk);
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        step(1'b0, 1'b0, JUNK);
        arm = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; hs = 1'b0; vs = 1'b0; arm = 1'b0; rgb = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One full line: HSYNC cycle carries pixel 0, each pixel held for 2 clocks,
    // then idle clocks so the offset instance also finishes the line.
    task automatic line(input logic [31:0] p4);
        step(1'b1, 1'b0, p4[31:24]);
        step(1'b0, 1'b0, p4[31:24]);
        step(1'b0, 1'b0, p4[23:16]);
        step(1'b0, 1'b0, p4[23:16]);
        step(1'b0, 1'b0, p4[15:8]);
        step(1'b0, 1'b0, p4[15:8]);
        step(1'b0, 1'b0, p4[7:0]);
        step(1'b0, 1'b0, p4[7:0]);
        repeat (4) step(1'b0, 1'b0, JUNK);
    endtask

    task automatic half_line(input logic [7:0] p0, input logic [7:0] p1);
        step(1'b1, 1'b0, p0);
        step(1'b0, 1'b0, p0);
        step(1'b0, 1'b0, p1);
        step(1'b0, 1'b0, p1);
    endtask

    task automatic run_frame(input vec_t v);
        arm_pulse();
        step(1'b0, 1'b1, JUNK);
        repeat (2) step(1'b0, 1'b0, JUNK);
        case (v.kind)
            0: begin
                line(v.pix[63:32]);
                line(v.pix[31:0]);
            end
            1: begin
                half_line(px(v.pix, 0), px(v.pix, 1));
                line(v.pix[47:16]);
            end
            default: begin
                half_line(px(v.pix, 0), px(v.pix, 1));
                step(1'b0, 1'b1, JUNK);
                repeat (3) step(1'b0, 1'b0, JUNK);
            end
        endcase
    endtask

    task automatic wait_done(input string name, input logic [2:0] mask);
        int t;
        t = 0;
        while (((done & mask) != mask) && (t < 50)) begin
            @(negedge clk);
            t++;
        end
        check({name, "/done"}, 32'(done & mask), 32'(mask));
    endtask

    initial begin
        vec_t e;
        logic [2:0] mask;

        rst = 1'b1; hs = 1'b0; vs = 1'b0; arm = 1'b0; rgb = 8'h00;

        tv[0] = mk("clean",   0, 64'h1C001C00_1C001C00, 8, 4, 4, 0, 1'b0, 1'b0);
        tv[1] = mk("mixed",   0, 64'h1CFF0003_1CFF0003, 8, 2, 2, 4, 1'b0, 1'b0);
        tv[2] = mk("early_h", 1, 64'h1C001C1C_FF000000, 6, 3, 2, 1, 1'b1, 1'b0);
        tv[3] = mk("early_v", 2, 64'h1CFF0000_00000000, 2, 1, 0, 1, 1'b0, 1'b1);
        tv[4] = mk("walk",    0, 64'h01020408_10204080, 8, 0, 0, 8, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset/dut%0d/busy", d), 32'(busy[d]), 0);
            check($sformatf("reset/dut%0d/done", d), 32'(done[d]), 0);
            check($sformatf("reset/dut%0d/cnts", d), 32'(fg[d] | bg[d] | oth[d]), 0);
            check($sformatf("reset/dut%0d/sig", d), 32'(sig[d]), 0);
            check($sformatf("reset/dut%0d/errs", d), 32'({lerr[d], ferr[d]}), 0);
        end

        // Table-driven frames through the scoreboard
        for (int i = 0; i < 5; i++) begin
            do_reset();
            exp_q.push_back(tv[i]);
            run_frame(tv[i]);
            mask = (tv[i].kind == 0) ? 3'b111 : 3'b001;
            wait_done(tv[i].name, mask);
            e = exp_q.pop_front();
            for (int d = 0; d < 3; d++) begin
                if (mask[d]) begin
                    check($sformatf("%s/dut%0d/fg", e.name, d), 32'(fg[d]), e.fg);
                    check($sformatf("%s/dut%0d/bg", e.name, d), 32'(bg[d]), e.bg);
                    check($sformatf("%s/dut%0d/other", e.name, d), 32'(oth[d]), e.oth);
                    check($sformatf("%s/dut%0d/sig", e.name, d), 32'(sig[d]), 32'(e.sig));
                    check($sformatf("%s/dut%0d/line_err", e.name, d), 32'(lerr[d]),
                          32'(e.lerr));
                    check($sformatf("%s/dut%0d/frame_err", e.name, d), 32'(ferr[d]),
                          32'(e.ferr));
                    check($sformatf("%s/dut%0d/busy", e.name, d), 32'(busy[d]), 0);
                end
            end
        end

        // First-sample timing: same edge for H_OFFSET=0, three edges later for 3
        do_reset();
        arm_pulse();
        step(1'b0, 1'b1, JUNK);
        step(1'b0, 1'b0, JUNK);
        step(1'b1, 1'b0, 8'h1C);
        check("hoff0/first_sample", 32'(fg[0]), 1);
        check("hoff0_inv/first_sample", 32'(fg[1]), 1);
        check("hoff3/e0", 32'(fg[2] + bg[2] + oth[2]), 0);
        step(1'b0, 1'b0, 8'h1C);
        check("hoff3/e1", 32'(fg[2] + bg[2] + oth[2]), 0);
        step(1'b0, 1'b0, 8'h00);
        check("hoff3/e2", 32'(fg[2] + bg[2] + oth[2]), 0);
        step(1'b0, 1'b0, 8'h00);
        check("hoff3/e3", 32'(fg[2]), 1);

        // ARM while busy is ignored; the frame still completes as a clean frame
        do_reset();
        arm_pulse();
        step(1'b0, 1'b1, JUNK);
        step(1'b0, 1'b0, JUNK);
        line(32'h1C001C00);
        check("busy_arm/mid_fg", 32'(fg[0]), 2);
        arm_pulse();
        check("busy_arm/still_busy", 32'(busy[0]), 1);
        check("busy_arm/not_cleared", 32'(fg[0] + bg[0]), 4);
        line(32'h1C001C00);
        wait_done("busy_arm", 3'b001);
        check("busy_arm/fg", 32'(fg[0]), 4);
        check("busy_arm/bg", 32'(bg[0]), 4);
        check("busy_arm/sig", 32'(sig[0]), 32'h0D58);

        // Re-ARM with DONE set: ARM wins, results clear on the next cycle
        arm = 1'b1;
        check("rearm/done_before", 32'(done[0]), 1);
        step(1'b0, 1'b0, JUNK);
        arm = 1'b0;
        check("rearm/done", 32'(done[0]), 0);
        check("rearm/fg", 32'(fg[0]), 0);
        check("rearm/sig", 32'(sig[0]), 0);
        check("rearm/busy", 32'(busy[0]), 1);

        // Asynchronous reset in the middle of a line, checked before any edge
        step(1'b0, 1'b1, JUNK);
        step(1'b0, 1'b0, JUNK);
        step(1'b1, 1'b0, 8'hFF);
        step(1'b0, 1'b0, 8'hFF);
        check("areset/pre_other", 32'(oth[0]), 1);
        #2 rst = 1'b1;
        #1;
        check("areset/busy", 32'(busy[0]), 0);
        check("areset/other", 32'(oth[0]), 0);
        check("areset/sig", 32'(sig[0]), 0);
        check("areset/done_errs", 32'({done[0], lerr[0], ferr[0]}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
